// File: rtl/result_bcd_converter.sv
// Converts the ALU's two's-complement result into sign plus packed BCD digits.
// A double-dabble engine handles one magnitude bit per clock, with valid/ready handshakes on both sides.
module result_bcd_converter #(
   parameter int DATA_WIDTH = 18,
   parameter int DIGITS     = 6
) (
   input  logic                    Clock,
   input  logic                    Reset_n,
   input  logic                    In_Valid,
   output logic                    In_Ready,
   input  logic [DATA_WIDTH-1:0]   Result,
   output logic                    Out_Valid,
   input  logic                    Out_Ready,
   output logic                    Negative,
   output logic [4*DIGITS-1:0]     BCD
);

   localparam int CW = $clog2(DATA_WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] CONVERT = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   logic [1:0]            state;
   logic [CW-1:0]         count;
   logic [DATA_WIDTH-1:0] mag;
   logic [4*DIGITS-1:0]   scratch;
   logic [4*DIGITS-1:0]   adjusted;
   logic [4*DIGITS-1:0]   shifted;
   logic                  neg_hold;

   // Every digit of 5 or more gets +3 so the following left shift carries correctly in decimal.
   always_comb begin
      adjusted = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) begin
            adjusted[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
         end
      end
   end

   assign shifted   = {adjusted[4*DIGITS-2:0], mag[DATA_WIDTH-1]};
   assign In_Ready  = (state == IDLE);
   assign Out_Valid = (state == DONE);

   // The sign is staged in neg_hold so Negative and BCD only update together on entry to DONE.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= IDLE;
         count    <= '0;
         mag      <= '0;
         scratch  <= '0;
         neg_hold <= 1'b0;
         Negative <= 1'b0;
         BCD      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (In_Valid) begin
                  neg_hold <= Result[DATA_WIDTH-1];
                  mag      <= Result[DATA_WIDTH-1] ? (~Result + DATA_WIDTH'(1)) : Result;
                  scratch  <= '0;
                  count    <= '0;
                  state    <= CONVERT;
               end
            end
            CONVERT: begin
               scratch <= shifted;
               mag     <= {mag[DATA_WIDTH-2:0], 1'b0};
               count   <= count + CW'(1);
               if (count == LAST) begin
                  BCD      <= shifted;
                  Negative <= neg_hold;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (Out_Ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Self-checking bench for result_bcd_converter: directed cases followed by a random
// stream, all compared against an arithmetic model of sign and decimal digits.
module tb_result_bcd_converter;

   localparam int DW = 18;
   localparam int DG = 6;

   logic          clock;
   logic          reset_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] result;
   logic          out_valid;
   logic          out_ready;
   logic          negative;
   logic [4*DG-1:0] bcd;

   int checks = 0;
   int errors = 0;

   result_bcd_converter #(.DATA_WIDTH(DW), .DIGITS(DG)) dut (
      .Clock(clock),
      .Reset_n(reset_n),
      .In_Valid(in_valid),
      .In_Ready(in_ready),
      .Result(result),
      .Out_Valid(out_valid),
      .Out_Ready(out_ready),
      .Negative(negative),
      .BCD(bcd)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected {sign, packed digits} from plain integer arithmetic.
   function automatic logic [4*DG:0] refModel(input logic [DW-1:0] r);
      int unsigned m;
      logic [4*DG-1:0] d;
      m = r[DW-1] ? ((32'd1 << DW) - 32'(r)) : 32'(r);
      d = '0;
      for (int i = 0; i < DG; i++) begin
         d[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return {r[DW-1], d};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Presents one value with Out_Ready held high and checks latency, result and return to IDLE.
   task automatic applyStimulus(input logic [DW-1:0] value);
      logic [4*DG:0] exp;
      int n;
      exp = refModel(value);
      @(negedge clock);
      out_ready = 1'b1;
      result    = value;
      in_valid  = 1'b1;
      checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clock);
         n++;
      end
      checkOutput("latency", 32'(n), 32'd18);
      checkOutput("bcd", 32'(bcd), 32'(exp[4*DG-1:0]));
      checkOutput("negative", 32'(negative), 32'(exp[4*DG]));
      @(negedge clock);
      checkOutput("out_valid_after_hs", 32'(out_valid), 32'd0);
      checkOutput("in_ready_after_hs", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [4*DG:0] exp;
      logic [4*DG:0] q[$];
      logic [4*DG:0] held;
      logic          stalled;
      int sent, got, cyc, n;

      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      result    = '0;
      #2;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_bcd", 32'(bcd), 32'd0);
      checkOutput("reset_negative", 32'(negative), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      applyStimulus(18'd65025);
      applyStimulus(18'd262139);
      applyStimulus(18'd0);
      applyStimulus(18'h20000);
      applyStimulus(18'h1FFFF);

      // Back-pressure: 255 completes, then 12 waits on In_Valid while Out_Ready stays low.
      @(negedge clock);
      out_ready = 1'b0;
      result    = 18'd255;
      in_valid  = 1'b1;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clock);
         n++;
      end
      checkOutput("bp_latency", 32'(n), 32'd18);
      result   = 18'd12;
      in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         checkOutput("bp_bcd_stable", 32'(bcd), 32'h000255);
         checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
         checkOutput("bp_out_valid_held", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      checkOutput("bp_in_ready_back", 32'(in_ready), 32'd1);
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clock);
         n++;
      end
      checkOutput("bp_second_latency", 32'(n), 32'd18);
      checkOutput("bp_second_bcd", 32'(bcd), 32'h000012);
      out_ready = 1'b1;
      @(negedge clock);

      // Asynchronous reset at iteration 9 of converting 999.
      result   = 18'd999;
      in_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      repeat (8) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
      checkOutput("abort_bcd", 32'(bcd), 32'd0);
      checkOutput("abort_negative", 32'(negative), 32'd0);
      checkOutput("abort_in_ready", 32'(in_ready), 32'd1);
      @(negedge clock);
      reset_n = 1'b1;
      n = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clock);
         if (out_valid) n++;
      end
      checkOutput("abort_no_stale_valid", 32'(n), 32'd0);
      applyStimulus(18'd999);

      // Random stream with random gaps on both handshakes.
      sent = 0;
      got = 0;
      cyc = 0;
      stalled = 1'b0;
      held = '0;
      while (got < 100 && cyc < 20000) begin
         @(negedge clock);
         cyc++;
         if (stalled) begin
            checkOutput("rand_valid_held", 32'(out_valid), 32'd1);
            checkOutput("rand_output_stable", 32'({negative, bcd}), 32'(held));
         end
         in_valid  = (sent < 100) && ($urandom_range(0, 2) != 0);
         result    = DW'($urandom);
         out_ready = ($urandom_range(0, 1) != 0);
         #1;
         if (in_valid && in_ready) begin
            q.push_back(refModel(result));
            sent++;
         end
         stalled = out_valid && !out_ready;
         held    = {negative, bcd};
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checkOutput("rand_unexpected_output", 32'd1, 32'd0);
            end else begin
               exp = q.pop_front();
               checkOutput("rand_result", 32'({negative, bcd}), 32'(exp));
            end
            got++;
         end
      end
      checkOutput("rand_count", 32'(got), 32'd100);
      checkOutput("rand_queue_empty", 32'(q.size()), 32'd0);

      @(negedge clock);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/result_bcd_converter.md
# result_bcd_converter

Sequential binary-to-BCD stage directly downstream of the calculator ALU. It accepts the ALU's two's-complement `Result` word over a valid/ready handshake. It converts the magnitude to packed BCD with an iterative shift-add-3 (double-dabble) engine, one bit per clock, and presents sign plus digits to the display stage over a second valid/ready handshake.

## Interface
- `DATA_WIDTH`, 18: width of the incoming ALU result (two's complement).
- `DIGITS`, 6: number of BCD digits produced. Must satisfy 10^DIGITS > 2^(DATA_WIDTH-1).
- `Clock` input 1: single clock; all state changes on rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `In_Valid` input 1: upstream has a result on `Result`.
- `In_Ready` output 1: block can accept a result (high only in IDLE).
- `Result` input DATA_WIDTH: ALU result, two's complement.
- `Out_Valid` output 1: `BCD` / `Negative` hold a completed conversion.
- `Out_Ready` input 1: downstream accepts the output.
- `Negative` output 1: 1 when the captured `Result` MSB was 1.
- `BCD` output 4*DIGITS: packed magnitude; digit 0 (units) in bits [3:0].

## Operation
- FSM states are IDLE, CONVERT and DONE.
- **IDLE**
  - `In_Ready`=1.
  - On `In_Valid`=1 at a rising edge (accept):
    - Capture `Negative` = `Result`[MSB].
    - Capture magnitude `Mag` = `Negative` ? (~`Result`+1) : `Result`, held in a DATA_WIDTH-bit register (unsigned; covers -2^(DATA_WIDTH-1)).
    - Clear the BCD scratch register and the bit counter; go to CONVERT.
- **CONVERT**, one iteration per clock:
  - Every scratch digit ≥5 gets +3.
  - Then {scratch, `Mag`} shifts left by 1, taking `Mag` MSB into scratch bit 0.
  - The counter increments each iteration.
  - After DATA_WIDTH iterations: copy the final scratch value to `BCD` and go to DONE.
- **DONE**
  - `Out_Valid`=1; `BCD` and `Negative` are held stable.
  - On `Out_Valid` & `Out_Ready` at an edge: go to IDLE and clear `Out_Valid`. `BCD`/`Negative` keep their last value until the next DONE.
- `In_Ready` is a combinational decode of state==IDLE. No new input is accepted during CONVERT or DONE, so inputs are never dropped or overwritten.
- Zero result: `Negative`=0, `BCD`=0.
- Results from an ALU divide-by-zero are converted bit-for-bit like any other value. X inputs are the ALU's problem and are not sanitised.
- The digit adjust applies to all DIGITS digits each iteration, including digits that are still zero.

## Timing
- Reset (`Reset_n`=0, asynchronous):
  - state=IDLE, counter=0.
  - `Out_Valid`=0, `Negative`=0, `BCD`=0.
  - `In_Ready`=1 as soon as reset asserts.
- Reset mid-CONVERT or in DONE aborts immediately and discards the conversion. No `Out_Valid` pulse follows.
- Latency: the accept is at edge k, so `Out_Valid` rises after edge k+DATA_WIDTH (18 cycles by default).
- Minimum spacing between accepts: DATA_WIDTH+2 cycles (accept, DATA_WIDTH iterations, one DONE cycle with `Out_Ready`=1).
- Output back-pressure:
  - With `Out_Ready`=0, DONE persists indefinitely.
  - `BCD`/`Negative` must not change while waiting.
  - `In_Ready` stays 0 while waiting.
- The output handshake completes on the same edge `Out_Ready` is sampled high. `In_Ready` is high in the following cycle.
- `In_Valid` low in IDLE: stay in IDLE, no register changes.
- `In_Valid` may drop without acceptance; only the value present at the accepting edge is used.

## Test plan
- Reset, then `Result`=65025 (0x0FE01) with `In_Valid` pulse and `Out_Ready`=1:
  - `Out_Valid` rises exactly 18 cycles after accept.
  - `BCD`=0x065025, `Negative`=0.
  - `In_Ready` returns one cycle later.
- `Result`=262139 (18-bit encoding of -5) -> `Negative`=1, `BCD`=0x000005. Then `Result`=0 -> `Negative`=0, `BCD`=0x000000.
- `Result`=0x20000 (most negative) -> `Negative`=1, `BCD`=0x131072. Then `Result`=0x1FFFF -> `Negative`=0, `BCD`=0x131071.
- Back-pressure: complete a conversion of 255 and hold `Out_Ready`=0 for 7 cycles while driving `In_Valid`=1 with `Result`=12.
  - `BCD`=0x000255 stays stable; `In_Ready`=0 throughout.
  - After `Out_Ready` pulses, 12 is accepted and yields 0x000012.
- Assert `Reset_n`=0 asynchronously at iteration 9 of converting 999:
  - `Out_Valid`, `BCD` and `Negative` clear immediately; `In_Ready`=1 immediately.
  - After release, no stale `Out_Valid`; a fresh 999 converts to 0x000999.
- Back-to-back stream of 100 random 18-bit results with random `In_Valid`/`Out_Ready` gaps, checked against a reference model:
  - Every accepted value is output exactly once, in order.
  - No output changes while `Out_Valid`=1 and `Out_Ready`=0.
